// File: rtl/dispensador_pkg.sv
// dispensador_pkg: state codes and button indices shared by the dispenser stages
package dispensador_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SELECT = 2'd1, DISPENSE = 2'd2, DONE = 2'd3} state_t;
  localparam int BTN_NEXT = 0;
  localparam int BTN_QTY = 1;
  localparam int BTN_START = 2;
  localparam int BTN_CANCEL = 3;
endpackage

// File: rtl/dispensador_fsm_if.sv
// dispensador_if: debounced buttons in, motor enables and display status out
interface dispensador_if #(parameter int NUM_GRAINS = 4);
  logic [3:0] btn;
  logic [NUM_GRAINS-1:0] motor;
  logic [$clog2(NUM_GRAINS)-1:0] grain_sel;
  logic [3:0] qty;
  logic [1:0] state_o;
  logic busy;
  logic done;
  modport master(output btn, input motor, grain_sel, qty, state_o, busy, done);
  modport slave(input btn, output motor, grain_sel, qty, state_o, busy, done);
endinterface

// File: rtl/detector_flanco.sv
// detector_flanco: rising-edge detector; history resets to ones so levels held through reset never fire
module detector_flanco #(parameter int WIDTH = 4) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] press
);
  logic [WIDTH-1:0] level_q;
  always_ff @(posedge clk)
    if (rst) level_q <= '1;
    else level_q <= level;
  assign press = level & ~level_q;
endmodule

// File: rtl/dispensador_fsm.sv
// dispensador_fsm: turns button presses into select/quantity/start/cancel and times the hopper motors
// define DISPENSADOR_TIMEOUT_EN to return SELECT to IDLE after TIMEOUT_CYCLES without a press
module dispensador_fsm
  import dispensador_pkg::*;
#(
  parameter int NUM_GRAINS = 4,
  parameter int QTY_MAX = 9,
  parameter int TICKS_PER_UNIT = 50_000_000,
  parameter int DONE_CYCLES = 100_000_000,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input logic clk,
  input logic rst,
  dispensador_if.slave bus
);
  localparam int GW = $clog2(NUM_GRAINS);
  localparam int TW = TICKS_PER_UNIT > 1 ? $clog2(TICKS_PER_UNIT) : 1;
  localparam int DW = DONE_CYCLES > 1 ? $clog2(DONE_CYCLES) : 1;
  state_t state;
  logic [NUM_GRAINS-1:0] motor;
  logic [GW-1:0] grain_sel;
  logic [3:0] qty;
  logic [3:0] units_left;
  logic [TW-1:0] tick_cnt;
  logic [DW-1:0] done_cnt;
  logic [3:0] press;
  logic busy;
  logic done;
  logic timeout_hit;
  logic to_idle;
  detector_flanco #(.WIDTH(4)) u_flanco (.clk(clk), .rst(rst), .level(bus.btn), .press(press));
`ifdef DISPENSADOR_TIMEOUT_EN
  localparam int OW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [OW-1:0] idle_cnt;
  always_ff @(posedge clk)
    idle_cnt <= (rst || state != SELECT || |press) ? '0 : idle_cnt + 1'b1;
  always_comb timeout_hit = state == SELECT && !(|press) && idle_cnt == OW'(TIMEOUT_CYCLES - 1);
`else
  logic unused_timeout;
  always_comb timeout_hit = 1'b0;
  always_comb unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif
  // every return to IDLE restores exactly the reset values, so both share one branch
  always_comb to_idle = press[BTN_CANCEL] || timeout_hit || (state == DONE && done_cnt == DW'(DONE_CYCLES - 1));
  always_ff @(posedge clk)
    if (rst || to_idle) begin
      state <= IDLE;
      motor <= '0;
      grain_sel <= '0;
      qty <= '0;
      units_left <= '0;
      tick_cnt <= '0;
      done_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else
      case (state)
        IDLE:
          if (!press[BTN_START] && (press[BTN_QTY] || press[BTN_NEXT])) begin
            state <= SELECT;
            qty <= 4'd1;
          end
        SELECT:
          if (press[BTN_START]) begin
            state <= DISPENSE;
            tick_cnt <= '0;
            units_left <= qty;
            motor <= NUM_GRAINS'(1) << grain_sel;
            busy <= 1'b1;
          end else if (press[BTN_QTY]) qty <= qty == 4'(QTY_MAX) ? 4'd1 : qty + 4'd1;
          else if (press[BTN_NEXT]) grain_sel <= grain_sel == GW'(NUM_GRAINS - 1) ? '0 : grain_sel + 1'b1;
        DISPENSE:
          if (tick_cnt == TW'(TICKS_PER_UNIT - 1)) begin
            tick_cnt <= '0;
            units_left <= units_left - 4'd1;
            if (units_left == 4'd1) begin
              state <= DONE;
              motor <= '0;
              busy <= 1'b0;
              done <= 1'b1;
              done_cnt <= '0;
            end
          end else tick_cnt <= tick_cnt + 1'b1;
        DONE: done_cnt <= done_cnt + 1'b1;
      endcase
  assign bus.motor = motor;
  assign bus.grain_sel = grain_sel;
  assign bus.qty = qty;
  assign bus.state_o = state;
  assign bus.busy = busy;
  assign bus.done = done;
endmodule
